// File: rtl/mux_pkg.sv
// Shared constants and types for the mux_32 read arbiter.
package mux_pkg;

    localparam int unsigned SEL_W     = 5;
    localparam int unsigned MUX_N     = 32;
    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 32;

    typedef logic [SEL_W-1:0] sel_t;

    // Pointer width for a requester index; at least one bit so ports stay legal for NREQ=1.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_32_arbiter_rr_pick.sv
// Round-robin winner search: first requester at or above rr_ptr, wrapping modulo NREQ.
module rr_pick
    import mux_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned PTR_W = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  winner
);

    // Walk the requesters in rotated order and keep only the first hit.
    always_comb begin
        logic        found;
        int unsigned idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                winner[idx[PTR_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_32_arbiter.sv
// Round-robin arbiter sharing one external 32:1 read mux among NREQ requesters.
// Stage G drives grant and mux_select; stage R captures mux_out and flags its owner.
module mux_32_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [SEL_W*NREQ-1:0] sel_in,
    input  logic                  stall,
    output logic [NREQ-1:0]       grant,
    output logic [SEL_W-1:0]      mux_select,
    input  logic [WIDTH-1:0]      mux_out,
    output logic [WIDTH-1:0]      rdata,
    output logic [NREQ-1:0]       rvalid,
    output logic                  busy
);

    localparam int unsigned PTR_W = ptr_width(NREQ);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [NREQ-1:0]  req_avail;
    logic [NREQ-1:0]  winner;
    sel_t             sel_next;

    // A requester whose grant pulse is high this cycle must re-present req.
    assign req_avail = req & ~grant;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req_avail),
        .rr_ptr (rr_ptr),
        .winner (winner)
    );

    // Winner's select and the pointer just past it; both hold when nobody wins.
    always_comb begin
        sel_next = mux_select;
        ptr_next = rr_ptr;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (winner[k]) begin
                sel_next = sel_in[k*SEL_W +: SEL_W];
                ptr_next = (k == NREQ - 1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    // Stage G: grant pulse, mux select and round-robin pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant      <= '0;
            mux_select <= '0;
            rr_ptr     <= '0;
        end else if (!stall) begin
            grant      <= winner;
            mux_select <= sel_next;
            rr_ptr     <= ptr_next;
        end
    end

    // Stage R: capture the shared mux output at the end of a grant cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= '0;
            rdata  <= '0;
        end else if (!stall) begin
            rvalid <= grant;
            if (|grant) begin
                rdata <= mux_out;
            end
        end
    end

    // busy tracks |grant | |rvalid, computed from their next values so it stays registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
        end else if (!stall) begin
            busy <= (|winner) | (|grant);
        end
    end

endmodule
